// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register bridge.
// Holds the FSM encoding and the byte/address widths used by the top and the read fetch.
package i2c_pkg;

    localparam int I2C_BYTE_W = 8;
    localparam int I2C_ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PTR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/i2c_rd_fetch.sv
// Read fetch: tx_rdy -> reg_rd -> tx_en, two cycles when unobstructed.
// Latency: 2 cycles, plus one per cycle that wr_busy blocks the issue.
// Backpressure: one in-flight read plus one queued; further requests are dropped (sticky ovf_q).
module i2c_rd_fetch
    import i2c_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_rdy,
    input  logic                  wr_busy,
    input  logic [I2C_BYTE_W-1:0] reg_rdata,
    output logic                  rd_go,
    output logic                  reg_rd,
    output logic                  tx_en,
    output logic [I2C_BYTE_W-1:0] tx_data
);

    logic [1:0]            wait_cnt;
    logic [1:0]            wait_nxt;
    logic [1:0]            occ;
    logic                  acc;
    logic                  ovf_q;
    logic [I2C_BYTE_W-1:0] data_q;

    // Occupancy counts queued requests plus the read whose data arrives next cycle.
    always_comb begin
        occ      = wait_cnt + {1'b0, reg_rd};
        acc      = tx_rdy && (occ < 2'd2);
        rd_go    = ((wait_cnt != 2'd0) || acc) && !wr_busy && !reg_rd;
        wait_nxt = wait_cnt + {1'b0, acc} - {1'b0, rd_go};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 2'd0;
            reg_rd   <= 1'b0;
            tx_en    <= 1'b0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wait_cnt <= wait_nxt;
            reg_rd   <= rd_go;
            tx_en    <= reg_rd;
            if (tx_en) begin
                data_q <= reg_rdata;
            end
            if (tx_rdy && !acc) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // reg_rdata is valid in the tx_en cycle itself; data_q holds it afterwards.
    assign tx_data = tx_en ? reg_rdata : data_q;

    ovf_never: assert property (@(posedge clk) disable iff (rst) !ovf_q);

endmodule

// File: rtl/i2c_reg_bridge.sv
// Pointer + auto-increment register front end behind the i2c_slave byte engine.
// Latency: rx_en -> reg_wr 1 cycle; tx_rdy -> tx_en 2 cycles (3 when colliding with a write).
// Backpressure: none upstream; reads queue one deep inside i2c_rd_fetch.
module i2c_reg_bridge
    import i2c_pkg::*;
#(
    parameter int ADDR_W   = I2C_ADDR_W,
    parameter int AUTO_INC = 1,
    parameter int PTR_RST  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [I2C_BYTE_W-1:0] rx_data,
    input  logic                  rx_en,
    input  logic                  tx_rdy,
    input  logic                  flag_start,
    input  logic                  flag_restart,
    input  logic                  flag_stop,
    output logic [I2C_BYTE_W-1:0] tx_data,
    output logic                  tx_en,
    output logic                  reg_wr,
    output logic                  reg_rd,
    output logic [ADDR_W-1:0]     reg_addr,
    output logic [I2C_BYTE_W-1:0] reg_wdata,
    input  logic [I2C_BYTE_W-1:0] reg_rdata,
    output logic [ADDR_W-1:0]     ptr,
    output logic                  busy
);

    localparam logic [ADDR_W-1:0] PTR_STEP = (AUTO_INC != 0) ? ADDR_W'(1) : '0;
    localparam logic [ADDR_W-1:0] PTR_INIT = ADDR_W'(PTR_RST);

    state_t state;
    state_t state_nxt;
    logic   ptr_load;
    logic   wr_go;
    logic   rd_go;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The received byte is consumed in the current state before any flag moves the FSM.
    always_comb begin
        state_nxt = state;
        ptr_load  = 1'b0;
        wr_go     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (flag_start) begin
                    state_nxt = ST_PTR;
                end
            end
            ST_PTR: begin
                ptr_load = rx_en;
                if (rx_en) begin
                    state_nxt = ST_DATA;
                end
                if (flag_start || flag_restart) begin
                    state_nxt = ST_PTR;
                end
            end
            ST_DATA: begin
                wr_go = rx_en;
                if (flag_start || flag_restart) begin
                    state_nxt = ST_PTR;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (flag_stop) begin
            state_nxt = ST_IDLE;
        end
    end

    // A pointer load or write owns ptr and the bus that cycle, so the read waits.
    i2c_rd_fetch u_fetch (
        .clk       (clk),
        .rst       (rst),
        .tx_rdy    (tx_rdy),
        .wr_busy   (ptr_load || wr_go),
        .reg_rdata (reg_rdata),
        .rd_go     (rd_go),
        .reg_rd    (reg_rd),
        .tx_en     (tx_en),
        .tx_data   (tx_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= PTR_INIT;
            reg_wr    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
        end else begin
            reg_wr <= wr_go;
            if (wr_go) begin
                reg_addr  <= ptr;
                reg_wdata <= rx_data;
                ptr       <= ptr + PTR_STEP;
            end else if (ptr_load) begin
                ptr <= ADDR_W'(rx_data);
            end else if (rd_go) begin
                reg_addr <= ptr;
                ptr      <= ptr + PTR_STEP;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// Scoreboard bench for i2c_reg_bridge: expected bus and tx events queued at stimulus time.
// A second instance with AUTO_INC=0 shares the stimulus for the held-pointer case.
module tb_i2c_reg_bridge;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         c;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_en, tx_rdy, flag_start, flag_restart, flag_stop;
    logic [7:0] tx_data, reg_addr, reg_wdata, ptr;
    logic       tx_en, reg_wr, reg_rd, busy;
    logic [7:0] reg_rdata = 8'h00;
    logic [7:0] tx_data0, reg_addr0, reg_wdata0, ptr0;
    logic       tx_en0, reg_wr0, reg_rd0, busy0;
    logic [7:0] reg_rdata0 = 8'h00;

    int  cyc = 0;
    int  n_chk = 0;
    int  n_err = 0;
    bit  mon_on = 1'b0;
    bit  mon0_on = 1'b0;
    ev_t exp_wr[$];
    ev_t exp_rd[$];
    ev_t exp_tx[$];
    ev_t exp_rd0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_reg_bridge #(.ADDR_W(8), .AUTO_INC(1), .PTR_RST(0)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_en(rx_en), .tx_rdy(tx_rdy),
        .flag_start(flag_start), .flag_restart(flag_restart), .flag_stop(flag_stop),
        .tx_data(tx_data), .tx_en(tx_en), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .ptr(ptr), .busy(busy)
    );

    i2c_reg_bridge #(.ADDR_W(8), .AUTO_INC(0), .PTR_RST(0)) dut0 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_en(rx_en), .tx_rdy(tx_rdy),
        .flag_start(flag_start), .flag_restart(flag_restart), .flag_stop(flag_stop),
        .tx_data(tx_data0), .tx_en(tx_en0), .reg_wr(reg_wr0), .reg_rd(reg_rd0),
        .reg_addr(reg_addr0), .reg_wdata(reg_wdata0), .reg_rdata(reg_rdata0),
        .ptr(ptr0), .busy(busy0)
    );

    // Register bus model: one-cycle read latency, data = addr + 0x80.
    always @(posedge clk) begin
        if (reg_rd)  reg_rdata  <= reg_addr + 8'h80;
        if (reg_rd0) reg_rdata0 <= reg_addr0 + 8'h80;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (mon_on) begin
            chk("wr_rd_excl", {31'd0, reg_wr & reg_rd}, 32'd0);
            if (reg_wr) begin
                chk("wr_expected", {31'd0, exp_wr.size() > 0}, 32'd1);
                if (exp_wr.size() > 0) begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", reg_addr, e.a);
                    chk("wr_data", reg_wdata, e.d);
                    chk("wr_cycle", cyc, e.c);
                end
            end
            if (reg_rd) begin
                chk("rd_expected", {31'd0, exp_rd.size() > 0}, 32'd1);
                if (exp_rd.size() > 0) begin
                    e = exp_rd.pop_front();
                    chk("rd_addr", reg_addr, e.a);
                    chk("rd_cycle", cyc, e.c);
                end
            end
            if (tx_en) begin
                chk("tx_expected", {31'd0, exp_tx.size() > 0}, 32'd1);
                if (exp_tx.size() > 0) begin
                    e = exp_tx.pop_front();
                    chk("tx_data", tx_data, e.d);
                    chk("tx_cycle", cyc, e.c);
                end
            end
        end
        if (mon0_on && reg_rd0) begin
            chk("rd0_expected", {31'd0, exp_rd0.size() > 0}, 32'd1);
            if (exp_rd0.size() > 0) begin
                e = exp_rd0.pop_front();
                chk("rd0_addr", reg_addr0, e.a);
                chk("rd0_cycle", cyc, e.c);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        rx_en = 1'b0; tx_rdy = 1'b0;
        flag_start = 1'b0; flag_restart = 1'b0; flag_stop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic t_flag(input int which);
        if (which == 0) flag_start = 1'b1;
        else if (which == 1) flag_restart = 1'b1;
        else flag_stop = 1'b1;
        step();
    endtask

    task automatic t_byte(input logic [7:0] d, input bit wr, input logic [7:0] a);
        rx_data = d;
        rx_en   = 1'b1;
        if (wr) exp_wr.push_back('{a: a, d: d, c: cyc + 1});
        step();
    endtask

    task automatic t_rdy(input logic [7:0] a);
        tx_rdy = 1'b1;
        exp_rd.push_back('{a: a, d: 8'h00, c: cyc + 1});
        exp_tx.push_back('{a: a, d: a + 8'h80, c: cyc + 2});
        step();
    endtask

    task automatic drained(input string tag);
        chk({tag, "_wr_left"}, exp_wr.size(), 0);
        chk({tag, "_rd_left"}, exp_rd.size(), 0);
        chk({tag, "_tx_left"}, exp_tx.size(), 0);
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_en = 1'b0; tx_rdy = 1'b0;
        flag_start = 1'b0; flag_restart = 1'b0; flag_stop = 1'b0;
        idle(3);
        chk("rst_reg_wr", {31'd0, reg_wr}, 0);
        chk("rst_reg_rd", {31'd0, reg_rd}, 0);
        chk("rst_tx_en", {31'd0, tx_en}, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_ptr", ptr, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_reg_addr", reg_addr, 0);
        rst = 1'b0;
        mon_on = 1'b1;
        idle(2);

        // Pointer then two auto-incremented writes.
        t_flag(0);
        chk("start_busy", {31'd0, busy}, 1);
        t_byte(8'h10, 0, 8'h00);
        t_byte(8'hAB, 1, 8'h10);
        t_byte(8'hCD, 1, 8'h11);
        idle(2);
        chk("wr_ptr", ptr, 8'h12);
        t_flag(2);
        chk("stop_busy", {31'd0, busy}, 0);
        idle(2);
        drained("wr");

        // Pointer write, restart, three sequential reads.
        t_flag(0);
        t_byte(8'h05, 0, 8'h00);
        t_flag(1);
        for (int i = 0; i < 3; i++) begin
            t_rdy(8'h05 + 8'(i));
            idle(4);
        end
        t_flag(2);
        chk("rd_ptr", ptr, 8'h08);
        drained("rd");

        // Wrap at 0xFF; the AUTO_INC=0 instance reads 0xFF twice.
        mon0_on = 1'b1;
        t_flag(0);
        t_byte(8'hFF, 0, 8'h00);
        t_flag(1);
        exp_rd0.push_back('{a: 8'hFF, d: 8'h00, c: cyc + 1});
        t_rdy(8'hFF);
        idle(4);
        exp_rd0.push_back('{a: 8'hFF, d: 8'h00, c: cyc + 1});
        t_rdy(8'h00);
        idle(4);
        t_flag(2);
        chk("wrap_ptr", ptr, 8'h01);
        chk("hold_ptr", ptr0, 8'hFF);
        chk("hold_rd_left", exp_rd0.size(), 0);
        mon0_on = 1'b0;
        drained("wrap");

        // Write and read request in the same cycle.
        t_flag(0);
        t_byte(8'h30, 0, 8'h00);
        rx_data = 8'h22; rx_en = 1'b1; tx_rdy = 1'b1;
        exp_wr.push_back('{a: 8'h30, d: 8'h22, c: cyc + 1});
        exp_rd.push_back('{a: 8'h31, d: 8'h00, c: cyc + 2});
        exp_tx.push_back('{a: 8'h31, d: 8'hB1, c: cyc + 3});
        step();
        idle(4);
        t_flag(2);
        chk("coll_ptr", ptr, 8'h32);
        drained("coll");

        // STOP together with the pointer byte, then a stray byte outside a transaction.
        t_flag(0);
        rx_data = 8'h40; rx_en = 1'b1; flag_stop = 1'b1;
        step();
        chk("stop_ptr", ptr, 8'h40);
        chk("stop_idle", {31'd0, busy}, 0);
        t_byte(8'h55, 0, 8'h00);
        idle(3);
        chk("stray_ptr", ptr, 8'h40);
        drained("stop");

        // Reset lands between the deferred read request and its reg_rd.
        t_flag(0);
        t_byte(8'h60, 0, 8'h00);
        rx_data = 8'h77; rx_en = 1'b1; tx_rdy = 1'b1;
        exp_wr.push_back('{a: 8'h60, d: 8'h77, c: cyc + 1});
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_reg_wr", {31'd0, reg_wr}, 0);
        chk("mid_rst_reg_rd", {31'd0, reg_rd}, 0);
        chk("mid_rst_tx_en", {31'd0, tx_en}, 0);
        chk("mid_rst_tx_data", tx_data, 0);
        chk("mid_rst_ptr", ptr, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_reg_addr", reg_addr, 0);
        chk("mid_rst_reg_wdata", reg_wdata, 0);
        idle(5);
        drained("rst");
        chk("ovf_clear", {31'd0, dut.u_fetch.ovf_q}, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_reg_bridge.md
Name: i2c_reg_bridge

Overview:
- Sits directly downstream of the i2c_slave byte engine and turns its byte stream into register-bus accesses.
- It is the standard "pointer + auto-increment" register map front end:
  - the first byte written after START/RESTART is the register pointer;
  - further written bytes are register writes;
  - read bytes are fetched from the register bus and handed back to the slave via write_data/write_en.
- The register bus is a simple single-cycle-write, fixed 1-cycle-read-latency master port.

Parameters:
- ADDR_W, 8, width of register pointer / reg_addr; pointer wraps modulo 2^ADDR_W.
- AUTO_INC, 1, 1: pointer increments after every data access; 0: pointer is held.
- PTR_RST, 0, pointer value after reset.

Ports:
- clk  input  1  system clock, same domain as i2c_slave.
- rst  input  1  synchronous reset, active-high.
- rx_data  input  8  byte received from master (i2c_slave read_data).
- rx_en  input  1  1-cycle strobe, rx_data valid (i2c_slave read_en).
- tx_rdy  input  1  1-cycle strobe, slave needs next byte to send (i2c_slave write_rdy).
- flag_start  input  1  START detected strobe.
- flag_restart  input  1  repeated START strobe.
- flag_stop  input  1  STOP strobe.
- tx_data  output  8  byte to send (to i2c_slave write_data).
- tx_en  output  1  1-cycle load strobe (to i2c_slave write_en).
- reg_wr  output  1  register write strobe.
- reg_rd  output  1  register read strobe.
- reg_addr  output  ADDR_W  register address for reg_wr/reg_rd.
- reg_wdata  output  8  write data.
- reg_rdata  input  8  read data, valid exactly 1 cycle after reg_rd.
- ptr  output  ADDR_W  current pointer.
- busy  output  1  high between START and STOP.

Behaviour:
- Reset values:
  - all outputs 0;
  - ptr = PTR_RST;
  - FSM = IDLE;
  - the read-pending flag is cleared.
- Reset has priority over every other event.
- Reset mid-transaction discards everything: no pending bus access completes.
- Main FSM states: IDLE, PTR, DATA.
  - IDLE: flag_start -> PTR, and busy=1.
  - PTR: rx_en latches ptr <= rx_data[ADDR_W-1:0] and goes to DATA. No reg_wr is issued. When ADDR_W>8, the upper bits are zero-filled.
  - DATA: each rx_en issues a write on the next cycle:
    - reg_wr=1, reg_addr=ptr, reg_wdata=rx_data;
    - in the same cycle ptr <= ptr+AUTO_INC (wrap at 2^ADDR_W).
  - flag_restart in PTR or DATA -> PTR. ptr is kept, so a restart into a read continues from the pointer.
  - flag_stop in any state -> IDLE, busy=0. ptr is kept for current-address reads.
- Read path, independent of PTR/DATA (tx_rdy only occurs in read transactions):
  - Cycle T: tx_rdy=1.
  - Cycle T+1: reg_rd=1, reg_addr=ptr, and ptr <= ptr+AUTO_INC.
  - Cycle T+2: tx_en=1, tx_data=reg_rdata.
  - Total latency tx_rdy -> tx_en is exactly 2 cycles, well inside the slave's ACK window.
  - tx_data holds its value until the next tx_en.
- A read in IDLE (no start seen) is still served; this covers current-address read robustness.
- Bus port rules:
  - reg_wr and reg_rd are never high in the same cycle.
  - Each is a single-cycle pulse.
  - reg_addr and reg_wdata are only meaningful while their strobe is high; otherwise they hold their last value.
- Collision handling:
  - If rx_en and tx_rdy arrive in the same cycle, the write is issued first.
  - The read is then deferred one cycle through a pending flag, and tx_en follows 3 cycles after tx_rdy.
  - A tx_rdy arriving while a read is outstanding (pending or awaiting rdata) is queued: depth 1 beyond the in-flight read.
  - A further overlap is dropped, and a sticky internal overflow bit is set. That bit is visible only for verification (asserted never set in legal traffic).
- flag_start while busy behaves as restart.
- flag_stop coinciding with rx_en: the byte is still processed (write or pointer), then the FSM goes to IDLE.
- Pointer wrap: ptr=2^ADDR_W-1 plus an access -> 0.

Decomposition:
- Shared package i2c_pkg:
  - FSM state encoding (IDLE/PTR/DATA);
  - byte width constant I2C_BYTE_W=8;
  - default ADDR_W.
- One natural sub-module, i2c_rd_fetch: the tx_rdy -> reg_rd -> tx_en 2-stage pipeline with its pending/queue flag and overflow bit.
- The top holds the FSM, pointer and write path.

Test Plan:
- START, rx_en 0x10, rx_en 0xAB, rx_en 0xCD, STOP -> reg_wr addr 0x10 data 0xAB, then addr 0x11 data 0xCD; ptr=0x12; busy falls after STOP.
- Pointer write then read:
  - stimulus: START, rx_en 0x05, RESTART, three tx_rdy pulses; bus model returns addr+0x80.
  - required: reg_rd on addr 0x05/0x06/0x07; tx_en exactly 2 cycles after each tx_rdy; tx_data 0x85/0x86/0x87.
- Wrap (ptr=0xFF) then tx_rdy ×2 -> reg_rd addr 0xFF then 0x00; with AUTO_INC=0 both reads are at 0xFF and ptr stays 0xFF.
- Same-cycle rx_en=0x22 (ptr=0x30) and tx_rdy:
  - required: reg_wr addr 0x30 at T+1; reg_rd addr 0x31 at T+2; tx_en at T+3.
  - reg_wr and reg_rd are never overlapping.
- rst asserted at the cycle between tx_rdy and reg_rd -> no reg_rd and no tx_en afterwards; ptr=PTR_RST; busy=0; all outputs 0 next cycle.
- STOP coincident with rx_en in PTR state -> ptr updated to rx_data; FSM IDLE; a following rx_en without START issues no reg_wr.
